// File: rtl/shift_add_mult6_if.sv
// Handshake and operand/result bundle between a multiply controller and shift_add_mult6.
interface shift_add_mult6_if;
    logic        start;
    logic [5:0]  a;
    logic [5:0]  b;
    logic        busy;
    logic        done;
    logic [11:0] product;

    modport master (output start, a, b, input  busy, done, product);
    modport slave  (input  start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_mult6.sv
// Sequential 6x6 unsigned shift-and-add multiplier: one 12-bit lookahead add stage,
// six data-independent steps, start/busy/done handshake and a held 12-bit product.
module shift_add_mult6 (
    input  logic                  clk,
    input  logic                  rst,
    shift_add_mult6_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // 12-bit add stage built from 4-bit lookahead groups; result is {carry_out, sum}.
    function automatic logic [12:0] cla_add12(input logic [11:0] x, input logic [11:0] y,
                                              input logic cin);
        logic [11:0] g;
        logic [11:0] p;
        logic [12:0] c;
        g    = x & y;
        p    = x ^ y;
        c    = 13'd0;
        c[0] = cin;
        for (int grp = 0; grp < 3; grp++) begin
            c[4*grp+1] = g[4*grp]   | (p[4*grp]   & c[4*grp]);
            c[4*grp+2] = g[4*grp+1] | (p[4*grp+1] & g[4*grp])
                       | (p[4*grp+1] & p[4*grp] & c[4*grp]);
            c[4*grp+3] = g[4*grp+2] | (p[4*grp+2] & g[4*grp+1])
                       | (p[4*grp+2] & p[4*grp+1] & g[4*grp])
                       | (p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
            c[4*grp+4] = g[4*grp+3] | (p[4*grp+3] & g[4*grp+2])
                       | (p[4*grp+3] & p[4*grp+2] & g[4*grp+1])
                       | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & g[4*grp])
                       | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
        end
        return {c[12], p ^ c[11:0]};
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic [11:0] mcand_r;
    logic [5:0]  mplier_r;
    logic [11:0] acc_r;
    logic [2:0]  step_r;
    logic [11:0] product_r;
    logic        busy_r;
    logic        done_r;
    logic [12:0] add_out_s;
    logic [11:0] step_sum_s;
    logic        accept_s;
    logic        last_step_s;

    assign add_out_s   = cla_add12(acc_r, mcand_r, 1'b0);
    assign step_sum_s  = mplier_r[0] ? add_out_s[11:0] : acc_r;
    assign accept_s    = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign last_step_s = (state_r == ST_RUN) && (step_r == 3'd5);

    // Next-state decode for the IDLE/RUN/DONE controller.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) next_state_s = ST_RUN;
                else           next_state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (step_r == 3'd5) next_state_s = ST_DONE;
                else                next_state_s = ST_RUN;
            end
            ST_DONE: begin
                if (bus.start) next_state_s = ST_RUN;
                else           next_state_s = ST_IDLE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register; busy/done are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == ST_RUN);
            done_r  <= (next_state_s == ST_DONE);
        end
    end

    // Datapath: operand load on accept, one add/shift per RUN cycle, product on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r   <= 12'd0;
            mplier_r  <= 6'd0;
            acc_r     <= 12'd0;
            step_r    <= 3'd0;
            product_r <= 12'd0;
        end else if (accept_s) begin
            mcand_r  <= {6'd0, bus.a};
            mplier_r <= bus.b;
            acc_r    <= 12'd0;
            step_r   <= 3'd0;
        end else if (state_r == ST_RUN) begin
            acc_r    <= step_sum_s;
            mcand_r  <= {mcand_r[10:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[5:1]};
            step_r   <= step_r + 3'd1;
            if (last_step_s) product_r <= step_sum_s;
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;

    shift_add_mult6_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .run   (state_r == ST_RUN),
        .carry (add_out_s[12])
    );

endmodule

// Operands never exceed 63*63, so the add stage must never carry out of bit 11.
module shift_add_mult6_chk (
    input logic clk,
    input logic rst,
    input logic run,
    input logic carry
);
    a_no_carry_out: assert property (@(posedge clk) disable iff (rst) !(run && carry));
endmodule

// File: tb/tb_shift_add_mult6.sv
// Self-checking bench for shift_add_mult6: directed scenarios plus randomized operands
// checked against plain a*b arithmetic and the fixed 6-cycle latency / 7-cycle throughput.
module tb_shift_add_mult6;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [11:0] exp_prod;

    shift_add_mult6_if bus ();

    shift_add_mult6 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] x, input logic [5:0] y);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
    endtask

    // Expects start to be presented already; checks E0..E6 and the held product.
    // inject_after > 0 pulses a start (1x1) after that edge, which must be ignored.
    task automatic wait_done(input logic [5:0] x, input logic [5:0] y, input int inject_after);
        int ref_val;
        ref_val = int'(x) * int'(y);
        for (int i = 0; i <= 6; i++) begin
            tick();
            bus.start = 1'b0;
            if (i < 6) begin
                check_val("busy_run", bus.busy, 1);
                check_val("done_run", bus.done, 0);
                check_val("prod_hold_run", bus.product, exp_prod);
            end else begin
                check_val("busy_done", bus.busy, 0);
                check_val("done_pulse", bus.done, 1);
                check_val("product", bus.product, ref_val[11:0]);
                exp_prod = ref_val[11:0];
            end
            if (inject_after != 0 && i == inject_after) begin
                bus.start = 1'b1;
                bus.a     = 6'd1;
                bus.b     = 6'd1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_val("busy_idle", bus.busy, 0);
            check_val("done_idle", bus.done, 0);
            check_val("prod_hold_idle", bus.product, exp_prod);
        end
    endtask

    initial begin
        logic [5:0] ra;
        logic [5:0] rb;
        total     = 0;
        bad       = 0;
        exp_prod  = 12'd0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 6'd0;
        bus.b     = 6'd0;
        tick();
        tick();
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_product", bus.product, 0);
        rst = 1'b0;
        idle(2);

        issue(6'd0, 6'd0);
        wait_done(6'd0, 6'd0, 0);
        idle(2);

        issue(6'd5, 6'd7);
        wait_done(6'd5, 6'd7, 0);
        check_val("p_5x7", bus.product, 12'h023);
        idle(20);

        issue(6'd63, 6'd63);
        wait_done(6'd63, 6'd63, 0);
        check_val("p_63x63", bus.product, 12'hF81);
        idle(1);

        // back-to-back: second start presented in the DONE cycle
        issue(6'd12, 6'd10);
        wait_done(6'd12, 6'd10, 0);
        check_val("p_12x10", bus.product, 12'h078);
        issue(6'd3, 6'd3);
        wait_done(6'd3, 6'd3, 0);
        check_val("p_3x3", bus.product, 12'h009);
        idle(2);

        // start during step 3 must be ignored
        issue(6'd9, 6'd9);
        wait_done(6'd9, 6'd9, 3);
        check_val("p_9x9", bus.product, 12'h051);
        idle(8);

        // reset aborts a 20x20 at step 4
        issue(6'd20, 6'd20);
        for (int i = 0; i <= 4; i++) begin
            tick();
            bus.start = 1'b0;
            check_val("busy_pre_abort", bus.busy, 1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_prod = 12'd0;
        check_val("abort_busy", bus.busy, 0);
        check_val("abort_done", bus.done, 0);
        check_val("abort_product", bus.product, 0);
        idle(10);
        issue(6'd2, 6'd3);
        wait_done(6'd2, 6'd3, 0);
        check_val("p_2x3", bus.product, 12'd6);
        idle(1);

        // reset and start together: start dropped
        rst = 1'b1;
        issue(6'd7, 6'd7);
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        exp_prod  = 12'd0;
        check_val("rst_start_busy", bus.busy, 0);
        idle(8);

        for (int n = 0; n < 40; n++) begin
            ra = 6'($urandom_range(0, 63));
            rb = 6'($urandom_range(0, 63));
            issue(ra, rb);
            wait_done(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
